// File: rtl/clm_mult_scheduler_pkg.sv
// Shared types and constants for the CLM multiplier scheduler: d-redundant state words,
// refresh polynomials, encoder matrix and the combined modulus P(x)*Q(x).
package clm_mult_scheduler_pkg;
   localparam int CLM_D     = 2;
   localparam int CLM_W     = 8 + CLM_D;
   localparam int CLM_N_REQ = 4;

   // P = x^8+x^4+x^3+x+1, Q = x^2+x+1; P*Q = x^10+x^9+x^8+x^6+1, bit k = coefficient of x^k
   localparam logic [CLM_W:0] PQ_POLY = 11'h741;

   typedef logic [CLM_W-1:0]              state_t;
   typedef logic [CLM_D-1:0]              red_poly_t;
   typedef logic [CLM_D-1:0][CLM_W-1:0]   nm_matrix_t;
   typedef logic [$clog2(CLM_N_REQ)-1:0]  req_tag_t;
endpackage

// File: rtl/clm_mult_scheduler_multiplier.sv
// Combinational CLM multiply: a*b mod P*Q, plus the refresh word r encoded through b_ext.
// Words are MSB-first: bit W-1 holds the x^0 coefficient.
module clm_mult_scheduler_multiplier
   import clm_mult_scheduler_pkg::*;
#(
   parameter int d = CLM_D
) (
   input  logic [8+d-1:0]          a,
   input  logic [8+d-1:0]          b,
   input  logic [d-1:0]            r,
   input  logic [d-1:0][8+d-1:0]   b_ext,
   output logic [8+d-1:0]          p
);
   localparam int W  = 8 + d;
   localparam int PW = 2 * W - 1;

   logic [W-1:0]  ar, br, red, refresh;
   logic [PW-1:0] prod;

   always_comb begin
      ar      = '0;
      br      = '0;
      red     = '0;
      refresh = '0;
      prod    = '0;
      for (int i = 0; i < W; i++) begin
         ar[i] = a[W-1-i];
         br[i] = b[W-1-i];
      end
      for (int i = 0; i < W; i++)
         if (br[i]) prod = prod ^ (PW'(ar) << i);
      // Reduce from the top down so each cleared bit stays cleared
      for (int k = PW - 1; k >= W; k--)
         if (prod[k]) prod = prod ^ (PW'(PQ_POLY) << (k - W));
      for (int i = 0; i < W; i++)
         red[W-1-i] = prod[i];
      for (int j = 0; j < d; j++)
         if (r[j]) refresh = refresh ^ b_ext[j];
      p = red ^ refresh;
   end
endmodule

// File: rtl/clm_mult_scheduler_rr_arbiter.sv
// Round-robin arbiter: first active request at or after ptr (wrapping) wins when en is high.
module clm_mult_scheduler_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int RW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [RW-1:0]    ptr,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [RW-1:0]    idx,
   output logic             any
);
   localparam int RW1 = RW + 1;

   logic [RW:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = {1'b0, ptr} + RW1'(k);
         if (pos >= RW1'(N_REQ)) pos = pos - RW1'(N_REQ);
         if (en && !any && req[pos[RW-1:0]]) begin
            grant[pos[RW-1:0]] = 1'b1;
            idx                = pos[RW-1:0];
            any                = 1'b1;
         end
      end
   end
endmodule

// File: rtl/clm_mult_scheduler.sv
// Shares one CLM multiplier among N_REQ requesters: round-robin grant gated by a fresh r,
// operand register stage, multiplier, result register stage.
module clm_mult_scheduler
   import clm_mult_scheduler_pkg::*;
#(
   parameter int d     = CLM_D,
   parameter int N_REQ = CLM_N_REQ
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  state_t [N_REQ-1:0]   req_a,
   input  state_t [N_REQ-1:0]   req_b,
   input  logic                 rnd_valid,
   output logic                 rnd_ready,
   input  red_poly_t            rnd,
   input  nm_matrix_t           B_ext,
   output logic [N_REQ-1:0]     resp_valid,
   input  logic [N_REQ-1:0]     resp_ready,
   output state_t               resp_data,
   output logic                 busy
);
   localparam int RW = $clog2(N_REQ);

   logic          v1_reg, v2_reg;
   logic [RW-1:0] tag1_reg, tag2_reg, ptr_reg, ptr_next;
   state_t        a1_reg, b1_reg, res2_reg, product;
   red_poly_t     r1_reg;
   logic          adv1, adv2, grant_en, grant_any;
   logic [RW-1:0] grant_idx;

   assign adv2     = ~v2_reg | resp_ready[tag2_reg];
   assign adv1     = ~v1_reg | adv2;
   // Held in reset no requester may see a grant, so reset also masks the enable
   assign grant_en = adv1 & rnd_valid & rst_n;
   assign ptr_next = (grant_idx == RW'(N_REQ - 1)) ? '0 : RW'(grant_idx + RW'(1));

   clm_mult_scheduler_rr_arbiter #(.N_REQ(N_REQ), .RW(RW)) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (ptr_reg),
      .en    (grant_en),
      .grant (req_ready),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   clm_mult_scheduler_multiplier #(.d(d)) u_multiplier (
      .a     (a1_reg),
      .b     (b1_reg),
      .r     (r1_reg),
      .b_ext (B_ext),
      .p     (product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_reg   <= 1'b0;
         v2_reg   <= 1'b0;
         tag1_reg <= '0;
         tag2_reg <= '0;
         ptr_reg  <= '0;
         a1_reg   <= '0;
         b1_reg   <= '0;
         r1_reg   <= '0;
         res2_reg <= '0;
      end else begin
         if (grant_any) begin
            v1_reg   <= 1'b1;
            tag1_reg <= grant_idx;
            a1_reg   <= req_a[grant_idx];
            b1_reg   <= req_b[grant_idx];
            r1_reg   <= rnd;
            ptr_reg  <= ptr_next;
         end else if (adv1) begin
            // Idle operands are zeroed so stale shares never sit on the multiplier inputs
            v1_reg <= 1'b0;
            a1_reg <= '0;
            b1_reg <= '0;
            r1_reg <= '0;
         end
         if (adv2) begin
            v2_reg   <= v1_reg;
            tag2_reg <= tag1_reg;
            res2_reg <= v1_reg ? product : '0;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_resp
         assign resp_valid[gi] = v2_reg & (tag2_reg == RW'(gi));
      end
   endgenerate

   assign rnd_ready = grant_any;
   assign resp_data = res2_reg;
   assign busy      = v1_reg | v2_reg;
endmodule

// File: tb/tb_clm_mult_scheduler.sv
// Directed and random checks of the CLM multiplier scheduler against an independent
// shift-and-reduce model of the modular product plus r*P refresh.
module tb_clm_mult_scheduler;
   import clm_mult_scheduler_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req_valid, req_ready, resp_valid, resp_ready;
   state_t [3:0]  req_a, req_b;
   logic          rnd_valid, rnd_ready, busy;
   red_poly_t     rnd;
   nm_matrix_t    B_ext;
   state_t        resp_data;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0] tag;
      state_t     data;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   clm_mult_scheduler #(.d(2), .N_REQ(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rnd_valid  (rnd_valid),
      .rnd_ready  (rnd_ready),
      .rnd        (rnd),
      .B_ext      (B_ext),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   function automatic state_t rev10(input state_t x);
      state_t y;
      for (int i = 0; i < 10; i++) y[i] = x[9-i];
      return y;
   endfunction

   // Horner-style multiply with reduction after every shift
   function automatic state_t model_mul(input state_t a, input state_t b);
      logic [10:0] acc;
      state_t      al, bl;
      al  = rev10(a);
      bl  = rev10(b);
      acc = '0;
      for (int i = 9; i >= 0; i--) begin
         acc = {acc[9:0], 1'b0};
         if (acc[10]) acc = acc ^ 11'h741;
         if (bl[i]) acc = acc ^ {1'b0, al};
      end
      return rev10(acc[9:0]);
   endfunction

   function automatic state_t model_op(input state_t a, input state_t b, input red_poly_t r);
      state_t rpoly;
      rpoly = '0;
      rpoly[9] = r[0];
      rpoly[8] = r[1];
      return model_mul(a, b) ^ model_mul(rpoly, 10'h362);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid  = '0;
      rnd_valid  = 1'b0;
      rnd        = '0;
      resp_ready = 4'hF;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 4'hF;
      rnd_valid = 1'b1;
      #3;
      n_cmp++;
      if (req_ready !== 4'h0 || rnd_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready: req_ready=%b rnd_ready=%b required 0000/0", req_ready, rnd_ready);
      end
      n_cmp++;
      if (resp_valid !== 4'h0 || resp_data !== 10'h000 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out: resp_valid=%b resp_data=%h busy=%b required 0000/000/0",
                  resp_valid, resp_data, busy);
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      $display("reset: checked idle outputs");
   endtask

   task automatic test_identity();
      state_t    va[4] = '{10'h200, 10'h100, 10'h200, 10'h200};
      state_t    vb[4] = '{10'h2A5, 10'h001, 10'h000, 10'h2A5};
      red_poly_t vr[4] = '{2'b00,   2'b00,   2'b01,   2'b10};
      state_t    ve[4] = '{10'h2A5, 10'h20B, 10'h362, 10'h314};
      for (int v = 0; v < 4; v++) begin
         req_valid = 4'b0001;
         req_a[0]  = va[v];
         req_b[0]  = vb[v];
         rnd       = vr[v];
         rnd_valid = 1'b1;
         @(negedge clk);
         n_cmp++;
         if (req_ready !== 4'b0001 || rnd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ident_grant[%0d]: req_ready=%b rnd_ready=%b required 0001/1", v, req_ready, rnd_ready);
         end
         cyc();
         req_valid = '0;
         @(negedge clk);
         n_cmp++;
         if (resp_valid !== 4'b0000 || rnd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ident_t1[%0d]: resp_valid=%b rnd_ready=%b required 0000/0", v, resp_valid, rnd_ready);
         end
         cyc();
         @(negedge clk);
         n_cmp++;
         if (resp_valid !== 4'b0001 || resp_data !== ve[v]) begin
            n_err++;
            $display("FAIL ident_resp[%0d]: resp_valid=%b resp_data=%h required 0001/%h",
                     v, resp_valid, resp_data, ve[v]);
         end
         $display("op a=%h b=%h r=%b -> resp %h", va[v], vb[v], vr[v], resp_data);
         cyc();
      end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_rdy, exp_rv;
      do_reset();
      req_valid  = 4'hF;
      rnd_valid  = 1'b1;
      resp_ready = 4'hF;
      for (int k = 0; k < 12; k++) begin
         if (k >= 10) req_valid = '0;
         @(negedge clk);
         exp_rdy = (k < 10) ? (4'b0001 << (k % 4)) : 4'b0000;
         exp_rv  = (k >= 2) ? (4'b0001 << ((k - 2) % 4)) : 4'b0000;
         n_cmp++;
         if (req_ready !== exp_rdy || resp_valid !== exp_rv) begin
            n_err++;
            $display("FAIL fair[%0d]: req_ready=%b resp_valid=%b required %b/%b",
                     k, req_ready, resp_valid, exp_rdy, exp_rv);
         end
         $display("fair cycle %0d: grant=%b resp=%b", k, req_ready, resp_valid);
         cyc();
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] rdy_tab[11]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      logic [3:0] rv_tab[11]   = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
      state_t     data_tab[11] = '{10'h000, 10'h000, 10'h011, 10'h011, 10'h011, 10'h011,
                                   10'h011, 10'h011, 10'h022, 10'h033, 10'h000};
      int acc = 0;
      rnd       = 2'b00;
      rnd_valid = 1'b1;
      req_a[1]  = 10'h200;
      for (int c = 0; c < 11; c++) begin
         req_valid  = (acc < 3) ? 4'b0010 : 4'b0000;
         req_b[1]   = 10'(17 * (acc + 1));
         resp_ready = (c < 7) ? 4'b1101 : 4'b1111;
         @(negedge clk);
         if (c == 7) begin
            n_cmp++;
            if (acc !== 2) begin
               n_err++;
               $display("FAIL bp_accepted: accepted=%0d during stall required 2", acc);
            end
         end
         n_cmp++;
         if (req_ready !== rdy_tab[c] || resp_valid !== rv_tab[c]) begin
            n_err++;
            $display("FAIL bp_hs[%0d]: req_ready=%b resp_valid=%b required %b/%b",
                     c, req_ready, resp_valid, rdy_tab[c], rv_tab[c]);
         end
         if (rv_tab[c] != 4'b0000) begin
            n_cmp++;
            if (resp_data !== data_tab[c]) begin
               n_err++;
               $display("FAIL bp_data[%0d]: resp_data=%h required %h", c, resp_data, data_tab[c]);
            end
         end
         if ((req_valid & req_ready) != 4'b0000) acc++;
         $display("bp cycle %0d: grant=%b resp=%b data=%h", c, req_ready, resp_valid, resp_data);
         cyc();
      end
   endtask

   task automatic test_starvation();
      idle_inputs();
      req_valid = 4'b0100;
      req_a[2]  = 10'h200;
      req_b[2]  = 10'h155;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++;
         if (req_ready !== 4'b0000 || rnd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL starve[%0d]: req_ready=%b rnd_ready=%b required 0000/0", c, req_ready, rnd_ready);
         end
         cyc();
      end
      rnd_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 4'b0100 || rnd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL starve_grant: req_ready=%b rnd_ready=%b required 0100/1", req_ready, rnd_ready);
      end
      $display("starve: grant=%b after rnd_valid", req_ready);
      cyc();
      req_valid = '0;
      cyc();
      cyc();
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL starve_drain: busy=%b required 0", busy);
      end
      cyc();
   endtask

   task automatic test_reset_midop();
      req_valid  = 4'hF;
      rnd_valid  = 1'b1;
      resp_ready = 4'h0;
      cyc();
      cyc();
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1 || resp_valid === 4'b0000) begin
         n_err++;
         $display("FAIL midop_full: busy=%b resp_valid=%b required 1/nonzero", busy, resp_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (resp_valid !== 4'b0000 || busy !== 1'b0 || resp_data !== 10'h000 || req_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL midop_async: resp_valid=%b busy=%b resp_data=%h req_ready=%b required 0000/0/000/0000",
                  resp_valid, busy, resp_data, req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL midop_ptr: req_ready=%b required 0001", req_ready);
      end
      $display("midop reset: first grant=%b", req_ready);
      cyc();
      idle_inputs();
      cyc();
      cyc();
   endtask

   task automatic test_random();
      int ops = 0;
      int cycles = 0;
      int ptr_model = 0;
      int win;
      logic legal;
      exp_t e;
      do_reset();
      exp_q.delete();
      while ((ops < 10000 || exp_q.size() > 0 || busy) && cycles < 80000) begin
         req_valid  = (ops < 10000) ? 4'($urandom) : 4'b0000;
         rnd_valid  = ($urandom_range(0, 3) != 0);
         resp_ready = 4'($urandom);
         rnd        = 2'($urandom);
         for (int i = 0; i < 4; i++) begin
            req_a[i] = 10'($urandom);
            req_b[i] = 10'($urandom);
         end
         @(negedge clk);
         legal = ((req_ready & ~req_valid) == 4'b0000) && $onehot0(req_ready) &&
                 (rnd_ready == (|req_ready)) && (!rnd_ready || rnd_valid);
         n_cmp++;
         if (legal !== 1'b1) begin
            n_err++;
            $display("FAIL rnd_legal: req_valid=%b req_ready=%b rnd_valid=%b rnd_ready=%b required legal handshake",
                     req_valid, req_ready, rnd_valid, rnd_ready);
         end
         if (req_ready != 4'b0000) begin
            win = -1;
            for (int i = 0; i < 4; i++)
               if (win < 0 && req_valid[(ptr_model + i) % 4]) win = (ptr_model + i) % 4;
            n_cmp++;
            if (req_ready !== (4'b0001 << win)) begin
               n_err++;
               $display("FAIL rnd_rr: req_ready=%b required winner %0d", req_ready, win);
            end
            e.tag  = 2'(win);
            e.data = model_op(req_a[win], req_b[win], rnd);
            exp_q.push_back(e);
            ptr_model = (win + 1) % 4;
            ops++;
         end
         if ((resp_valid & resp_ready) != 4'b0000) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL rnd_extra: resp_valid=%b resp_data=%h with no op outstanding", resp_valid, resp_data);
            end else begin
               e = exp_q.pop_front();
               if (resp_valid !== (4'b0001 << e.tag) || resp_data !== e.data) begin
                  n_err++;
                  $display("FAIL rnd_resp: resp_valid=%b resp_data=%h required tag %0d data %h",
                           resp_valid, resp_data, e.tag, e.data);
               end
            end
         end
         cyc();
         cycles++;
      end
      n_cmp++;
      if (ops != 10000 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rnd_done: ops=%0d outstanding=%0d required 10000/0 within cycle budget",
                  ops, exp_q.size());
      end
      $display("random: %0d ops in %0d cycles", ops, cycles);
   endtask

   initial begin
      req_a    = '0;
      req_b    = '0;
      B_ext[0] = 10'h362;
      B_ext[1] = 10'h1B1;
      idle_inputs();
      test_reset();
      test_identity();
      test_fairness();
      test_backpressure();
      test_starvation();
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
